// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register file write port between the in-order
// writeback stage and queued results from the multiply/divide unit (MDU).
// Writeback wins by default. A starvation counter forces one stall cycle so
// that a waiting MDU result is eventually written.
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              mdu_valid_i,
    input  logic [4:0]        mdu_addr_i,
    input  logic [DATA_W-1:0] mdu_data_i,
    output logic              mdu_ready_o,
    input  logic [4:0]        rd_addr_a_i,
    input  logic [4:0]        rd_addr_b_i,
    output logic              rf_we_o,
    output logic [4:0]        rf_addr_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic              stall_o,
    output logic              hazard_o
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [4:0]        r_addrMem [DEPTH];
    logic [DATA_W-1:0] r_dataMem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_waitCnt;

    logic              r_rfWe;
    logic [4:0]        r_rfAddr;
    logic [DATA_W-1:0] r_rfData;

    logic w_full;
    logic w_empty;
    logic w_wbReq;
    logic w_push;
    logic w_stall;
    logic w_grantHead;
    logic w_grantWb;
    logic w_hazard;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_wbReq     = wb_we_i && (wb_addr_i != 5'd0);
    // A result for register 0 is accepted from the MDU but simply dropped.
    assign w_push      = mdu_valid_i && !w_full && (mdu_addr_i != 5'd0);
    assign w_stall     = (r_waitCnt == WAIT_W'(MAX_WAIT)) && !w_empty;
    assign w_grantHead = w_stall || (!w_wbReq && !w_empty);
    assign w_grantWb   = !w_stall && w_wbReq;

    assign mdu_ready_o = !w_full;
    assign stall_o     = w_stall;
    assign hazard_o    = w_hazard;
    assign rf_we_o     = r_rfWe;
    assign rf_addr_o   = r_rfAddr;
    assign rf_data_o   = r_rfData;

    // FIFO payload storage; contents are only meaningful where r_valid is set.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addrMem[r_wrPtr] <= mdu_addr_i;
            r_dataMem[r_wrPtr] <= mdu_data_i;
        end
    end

    // FIFO pointers, occupancy and per-entry valid flags (valid feeds the hazard check).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_grantHead) begin
                r_rdPtr          <= r_rdPtr + PTR_W'(1);
                r_valid[r_rdPtr] <= 1'b0;
            end
            if (w_push) begin
                r_wrPtr          <= r_wrPtr + PTR_W'(1);
                r_valid[r_wrPtr] <= 1'b1;
            end
            case ({w_push, w_grantHead})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Counts how long a non-empty FIFO has gone without its head being written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_waitCnt <= '0;
        end else if (w_grantHead || w_empty) begin
            r_waitCnt <= '0;
        end else if (r_waitCnt != WAIT_W'(MAX_WAIT)) begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
        end
    end

    // Registered write port: load from the granted source, otherwise drop enable and hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rfWe   <= 1'b0;
            r_rfAddr <= '0;
            r_rfData <= '0;
        end else if (w_grantHead) begin
            r_rfWe   <= 1'b1;
            r_rfAddr <= r_addrMem[r_rdPtr];
            r_rfData <= r_dataMem[r_rdPtr];
        end else if (w_grantWb) begin
            r_rfWe   <= 1'b1;
            r_rfAddr <= wb_addr_i;
            r_rfData <= wb_data_i;
        end else begin
            r_rfWe   <= 1'b0;
        end
    end

    // Flags a decode source register that is still waiting in the FIFO.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] &&
                (((rd_addr_a_i != 5'd0) && (r_addrMem[i] == rd_addr_a_i)) ||
                 ((rd_addr_b_i != 5'd0) && (r_addrMem[i] == rd_addr_b_i)))) begin
                w_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed vectors, with expected register
// file writes queued in write order and checked by an independent monitor.
module tb_wb_port_arbiter;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wb_we_i = 1'b0;
    logic [4:0]        wb_addr_i = '0;
    logic [DATA_W-1:0] wb_data_i = '0;
    logic              mdu_valid_i = 1'b0;
    logic [4:0]        mdu_addr_i = '0;
    logic [DATA_W-1:0] mdu_data_i = '0;
    logic              mdu_ready_o;
    logic [4:0]        rd_addr_a_i = '0;
    logic [4:0]        rd_addr_b_i = '0;
    logic              rf_we_o;
    logic [4:0]        rf_addr_o;
    logic [DATA_W-1:0] rf_data_o;
    logic              stall_o;
    logic              hazard_o;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    wr_t monEntry;
    int  totalChecks = 0;
    int  badChecks   = 0;

    wb_port_arbiter #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .mdu_valid_i(mdu_valid_i),
        .mdu_addr_i (mdu_addr_i),
        .mdu_data_i (mdu_data_i),
        .mdu_ready_o(mdu_ready_o),
        .rd_addr_a_i(rd_addr_a_i),
        .rd_addr_b_i(rd_addr_b_i),
        .rf_we_o    (rf_we_o),
        .rf_addr_o  (rf_addr_o),
        .rf_data_o  (rf_data_o),
        .stall_o    (stall_o),
        .hazard_o   (hazard_o)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        totalChecks++;
        if (actual !== required) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic required);
        checkOutput(name, {31'b0, actual}, {31'b0, required});
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs, then return just after the rising edge.
    task automatic applyStimulus(input logic wbWe, input logic [4:0] wbAddr, input logic [31:0] wbData,
                                 input logic mduValid, input logic [4:0] mduAddr, input logic [31:0] mduData);
        wb_we_i     = wbWe;
        wb_addr_i   = wbAddr;
        wb_data_i   = wbData;
        mdu_valid_i = mduValid;
        mdu_addr_i  = mduAddr;
        mdu_data_i  = mduData;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Monitor: every write seen on the port must be the next expected one.
    always @(negedge clk) begin
        if (rst && rf_we_o) begin
            if (expQ.size() == 0) begin
                totalChecks++;
                badChecks++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write", rf_addr_o, rf_data_o);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("mon_addr", {27'b0, rf_addr_o}, {27'b0, monEntry.addr});
                checkOutput("mon_data", rf_data_o, monEntry.data);
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values while reset is held.
        #2;
        checkBit("rst_we", rf_we_o, 1'b0);
        checkOutput("rst_addr", {27'b0, rf_addr_o}, 32'h0);
        checkOutput("rst_data", rf_data_o, 32'h0);
        checkBit("rst_stall", stall_o, 1'b0);
        checkBit("rst_hazard", hazard_o, 1'b0);
        checkBit("rst_ready", mdu_ready_o, 1'b1);
        #10;
        rst = 1'b1;
        idle();
        checkBit("idle_we", rf_we_o, 1'b0);

        // Writeback-only traffic, then a write to register 0 that must be dropped.
        expectWrite(5'd5, 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        checkBit("wb_we", rf_we_o, 1'b1);
        checkOutput("wb_addr", {27'b0, rf_addr_o}, 32'd5);
        checkOutput("wb_data", rf_data_o, 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 32'h00001111, 1'b0, 5'd0, 32'h0);
        checkBit("wb_zero_we", rf_we_o, 1'b0);
        checkOutput("wb_zero_hold_addr", {27'b0, rf_addr_o}, 32'd5);
        checkOutput("wb_zero_hold_data", rf_data_o, 32'hDEADBEEF);

        // MDU result for register 0 completes the handshake but is never written.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
        checkBit("mdu_zero_ready", mdu_ready_o, 1'b1);
        idle();
        checkBit("mdu_zero_we", rf_we_o, 1'b0);

        // Idle drain with hazard visibility while queued.
        rd_addr_a_i = 5'd7;
        expectWrite(5'd7, 32'h12);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12);
        checkBit("drain_hazard_q", hazard_o, 1'b1);
        checkBit("drain_no_bypass", rf_we_o, 1'b0);
        idle();
        checkBit("drain_we", rf_we_o, 1'b1);
        checkOutput("drain_addr", {27'b0, rf_addr_o}, 32'd7);
        checkOutput("drain_data", rf_data_o, 32'h12);
        checkBit("drain_hazard_clr", hazard_o, 1'b0);
        rd_addr_a_i = 5'd0;
        idle();

        // Starvation: WB every cycle, one MDU entry; stall in the 5th grantable cycle.
        expectWrite(5'd1, 32'h10000001);
        applyStimulus(1'b1, 5'd1, 32'h10000001, 1'b1, 5'd20, 32'hA0);
        checkBit("starve_stall_1", stall_o, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            expectWrite(5'(k), 32'h10000000 + 32'(k));
            applyStimulus(1'b1, 5'(k), 32'h10000000 + 32'(k), 1'b0, 5'd0, 32'h0);
            checkBit($sformatf("starve_stall_%0d", k), stall_o, (k == 5));
        end
        expectWrite(5'd20, 32'hA0);
        expectWrite(5'd6, 32'h10000006);
        applyStimulus(1'b1, 5'd6, 32'h10000006, 1'b0, 5'd0, 32'h0);
        checkBit("starve_stall_off", stall_o, 1'b0);
        checkBit("starve_forced_we", rf_we_o, 1'b1);
        checkOutput("starve_forced_addr", {27'b0, rf_addr_o}, 32'd20);
        checkOutput("starve_forced_data", rf_data_o, 32'hA0);
        applyStimulus(1'b1, 5'd6, 32'h10000006, 1'b0, 5'd0, 32'h0);
        checkOutput("starve_held_addr", {27'b0, rf_addr_o}, 32'd6);
        idle();
        checkBit("starve_held_once", rf_we_o, 1'b0);

        // Full FIFO: third result held until the forced drain frees a slot.
        expectWrite(5'd2, 32'h20000002);
        applyStimulus(1'b1, 5'd2, 32'h20000002, 1'b1, 5'd21, 32'hB1);
        checkBit("full_ready_1", mdu_ready_o, 1'b1);
        expectWrite(5'd3, 32'h20000003);
        applyStimulus(1'b1, 5'd3, 32'h20000003, 1'b1, 5'd22, 32'hB2);
        checkBit("full_ready_0", mdu_ready_o, 1'b0);
        for (int k = 4; k <= 6; k++) begin
            expectWrite(5'(k), 32'h20000000 + 32'(k));
            applyStimulus(1'b1, 5'(k), 32'h20000000 + 32'(k), 1'b1, 5'd23, 32'hB3);
            checkBit($sformatf("full_held_ready_%0d", k), mdu_ready_o, 1'b0);
            checkBit($sformatf("full_stall_%0d", k), stall_o, (k == 6));
        end
        expectWrite(5'd21, 32'hB1);
        expectWrite(5'd7, 32'h20000007);
        applyStimulus(1'b1, 5'd7, 32'h20000007, 1'b1, 5'd23, 32'hB3);
        checkBit("full_ready_back", mdu_ready_o, 1'b1);
        checkOutput("full_forced_addr", {27'b0, rf_addr_o}, 32'd21);
        applyStimulus(1'b1, 5'd7, 32'h20000007, 1'b1, 5'd23, 32'hB3);
        checkOutput("full_wb_addr", {27'b0, rf_addr_o}, 32'd7);
        checkBit("full_third_accepted", mdu_ready_o, 1'b0);
        expectWrite(5'd22, 32'hB2);
        expectWrite(5'd23, 32'hB3);
        idle();
        checkOutput("full_drain_m2", {27'b0, rf_addr_o}, 32'd22);
        idle();
        checkOutput("full_drain_m3", {27'b0, rf_addr_o}, 32'd23);
        checkBit("full_empty_ready", mdu_ready_o, 1'b1);
        idle();
        checkBit("full_done_we", rf_we_o, 1'b0);

        // Simultaneous push/pop at occupancy 1 across pointer wrap.
        expectWrite(5'd24, 32'hC1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'hC1);
        checkBit("pp_first_we", rf_we_o, 1'b0);
        for (int j = 2; j <= 4; j++) begin
            expectWrite(5'(23 + j), 32'hC0 + 32'(j));
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(23 + j), 32'hC0 + 32'(j));
            checkOutput($sformatf("pp_addr_%0d", j), {27'b0, rf_addr_o}, 32'(22 + j));
            checkOutput($sformatf("pp_data_%0d", j), rf_data_o, 32'hC0 + 32'(j - 1));
            checkBit($sformatf("pp_ready_%0d", j), mdu_ready_o, 1'b1);
            rd_addr_a_i = 5'(22 + j);
            #1;
            checkBit($sformatf("pp_hazard_popped_%0d", j), hazard_o, 1'b0);
            rd_addr_a_i = 5'(23 + j);
            #1;
            checkBit($sformatf("pp_hazard_queued_%0d", j), hazard_o, 1'b1);
            rd_addr_a_i = 5'd0;
        end
        idle();
        checkOutput("pp_last_addr", {27'b0, rf_addr_o}, 32'd27);
        idle();
        checkBit("pp_done_we", rf_we_o, 1'b0);

        // Reset mid-operation with two queued entries.
        expectWrite(5'd8, 32'h30000008);
        applyStimulus(1'b1, 5'd8, 32'h30000008, 1'b1, 5'd26, 32'hE1);
        expectWrite(5'd9, 32'h30000009);
        applyStimulus(1'b1, 5'd9, 32'h30000009, 1'b1, 5'd27, 32'hE2);
        checkBit("mid_full", mdu_ready_o, 1'b0);
        rd_addr_b_i = 5'd26;
        #1;
        checkBit("mid_hazard", hazard_o, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        wb_we_i     = 1'b0;
        mdu_valid_i = 1'b0;
        #1;
        checkBit("mid_rst_we", rf_we_o, 1'b0);
        checkOutput("mid_rst_addr", {27'b0, rf_addr_o}, 32'h0);
        checkOutput("mid_rst_data", rf_data_o, 32'h0);
        checkBit("mid_rst_stall", stall_o, 1'b0);
        checkBit("mid_rst_hazard", hazard_o, 1'b0);
        checkBit("mid_rst_ready", mdu_ready_o, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd_addr_b_i = 5'd0;
        idle();
        checkBit("post_rst_we_1", rf_we_o, 1'b0);
        checkBit("post_rst_ready", mdu_ready_o, 1'b1);
        idle();
        checkBit("post_rst_we_2", rf_we_o, 1'b0);
        expectWrite(5'd10, 32'h3000000A);
        applyStimulus(1'b1, 5'd10, 32'h3000000A, 1'b0, 5'd0, 32'h0);
        checkOutput("post_rst_addr", {27'b0, rf_addr_o}, 32'd10);

        idle();
        idle();
        idle();
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the in-order writeback stage and the result channel of the long-latency multiply/divide unit (MDU). Writeback-stage writes have priority. MDU results are queued in a small FIFO and drained into idle write-port cycles. A starvation counter freezes the pipeline for one cycle when a queued result has waited too long. The block sits between the MEM/WB pipeline register outputs and the register file write port, and also feeds a hazard flag to the hazard unit.

## Interface
- DATA_W, 32, width of written data
- DEPTH, 2, MDU result FIFO depth; power of two, ≥2
- MAX_WAIT, 4, consecutive ungranted cycles of a non-empty FIFO before a forced grant; ≥1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wb_we_i  in  1  writeback-stage write request
- wb_addr_i  in  5  writeback destination register
- wb_data_i  in  DATA_W  writeback data
- mdu_valid_i  in  1  MDU result valid
- mdu_addr_i  in  5  MDU destination register
- mdu_data_i  in  DATA_W  MDU result
- mdu_ready_o  out  1  FIFO can accept a result
- rd_addr_a_i, rd_addr_b_i  in  5 each  decode-stage source registers, for the hazard check
- rf_we_o  out  1  register file write enable (registered)
- rf_addr_o  out  5  register file write address (registered)
- rf_data_o  out  DATA_W  register file write data (registered)
- stall_o  out  1  freeze the pipeline for this cycle
- hazard_o  out  1  a source register matches a queued MDU destination

## Operation
- **Request definitions.**
  - WB request: wb_we_i=1 and wb_addr_i≠0.
  - A write to register 0 is never issued.
- **MDU handshake.**
  - mdu_ready_o = !full. It is registered-state based and is not lowered by a same-cycle pop.
  - Push occurs when mdu_valid_i && mdu_ready_o.
  - A push with mdu_addr_i=0 completes the handshake but the result is discarded and not queued.
- **Grant priority** (one grant per cycle):
  1. If stall_o=1: grant the FIFO head. The WB input is ignored, because upstream holds it while frozen.
  2. Else if there is a WB request: grant WB.
  3. Else if the FIFO is non-empty: grant the FIFO head (pop).
  4. Else: no grant.
- **No bypass.** A pushed entry is not grantable in its push cycle.
- **Simultaneous push and pop.** Legal whenever not full. Occupancy is unchanged.
- **Starvation counter** wait_cnt (range 0..MAX_WAIT):
  - Cleared on a head grant, or when the FIFO is empty.
  - Otherwise incremented, saturating at MAX_WAIT.
  - stall_o = (wait_cnt==MAX_WAIT) && FIFO non-empty. This is combinational from registered state.
  - The forced grant clears the counter, so stall_o lasts exactly one cycle per forced drain.
- **Hazard output.**
  - hazard_o=1 if any valid FIFO entry's address equals a nonzero rd_addr_a_i or rd_addr_b_i.
  - It is combinational.
  - Write ordering between WB and queued MDU results is the hazard unit's responsibility, using hazard_o.
- **Output register.**
  - On a grant: rf_we_o=1, and rf_addr_o/rf_data_o are loaded from the granted source.
  - With no grant: rf_we_o=0, and rf_addr_o/rf_data_o hold their previous values.

## Timing
- **Reset values** (rst=0, asynchronous): rf_we_o=0, rf_addr_o=0, rf_data_o=0, FIFO empty (pointers and count 0), wait_cnt=0, stall_o=0, hazard_o=0, mdu_ready_o=1.
- **Reset mid-operation:** queued MDU results are lost. After rst releases, the first grant is possible on the next rising edge.
- **WB latency:** a request sampled at edge N gives rf_we_o=1 after edge N (one cycle).
- **MDU latency:** a push at edge N is earliest written after edge N+1.
- **Worst-case MDU latency** for the head entry, with continuous WB traffic: MAX_WAIT ungranted cycles, then the forced stall cycle, then the write visible one cycle later.
- **FIFO full:** mdu_ready_o=0; the MDU must hold mdu_valid_i and its data.
- **Pointer wrap:** pointers wrap modulo DEPTH. Full/empty are derived from an occupancy count of width clog2(DEPTH)+1.
- **Throughput:** exactly one register file write per cycle maximum. stall_o never asserts while the FIFO is empty.

## Test plan
- **Reset:** drive rst=0 mid-traffic with 2 entries queued → all outputs at reset values immediately; after release, mdu_ready_o=1 and no rf_we_o until a new request.
- **WB only:** wb_we_i=1, addr=5, data=0xDEADBEEF at edge N → rf_we_o=1, rf_addr_o=5, rf_data_o=0xDEADBEEF after N. A request with addr=0 → rf_we_o stays 0.
- **Idle drain:** push MDU addr=7, data=0x12 with WB idle → rf_we_o=1, rf_addr_o=7 two cycles after the push. During queuing, hazard_o=1 when rd_addr_a_i=7, and 0 after the drain.
- **Full:** DEPTH=2, hold WB busy, push two results → mdu_ready_o=0 and the third valid is held. After a forced drain, ready returns to 1 and the third push is accepted.
- **Starvation:** MAX_WAIT=4, WB request every cycle, one MDU entry queued → stall_o=1 in exactly the 5th cycle after the push becomes grantable. The MDU value is written, then WB writes resume, and the held WB request is written once, not dropped.
- **Simultaneous push/pop at occupancy 1:** occupancy stays 1, FIFO order is preserved across pointer wrap, and the values come out in push order.
